// File: rtl/region_attr_table_pkg.sv
// Shared types for the region attribute table: rule layout, attribute bit
// positions and the configuration field encoding.
package region_attr_table_pkg;

  localparam int MaxAddrWidth = 64;

  typedef logic [MaxAddrWidth-1:0] addr_max_t;
  typedef logic [2:0]              attr_t;

  // Attribute bit positions inside attr_t
  localparam int AttrCached  = 0;
  localparam int AttrExec    = 1;
  localparam int AttrNonIdem = 2;

  // Rules are stored at the maximum width; only the low AddrWidth bits of
  // base/length are ever written or compared.
  typedef struct packed {
    addr_max_t base;
    addr_max_t length;
    attr_t     attr;
  } rule_t;

  typedef enum logic [1:0] {
    FieldBase   = 2'd0,
    FieldLength = 2'd1,
    FieldAttr   = 2'd2,
    FieldLock   = 2'd3
  } cfg_field_e;

endpackage

// File: rtl/region_attr_table_if.sv
// Bus bundle for the region attribute table: config port, lookup request,
// lookup result and lock status.
interface region_attr_table_if #(
  parameter int NrRules   = 4,
  parameter int AddrWidth = 64
);
  localparam int IdxW = (NrRules > 1) ? $clog2(NrRules) : 1;

  logic                 cfg_req_i;
  logic                 cfg_we_i;
  logic [IdxW-1:0]      cfg_idx_i;
  logic [1:0]           cfg_field_i;
  logic [AddrWidth-1:0] cfg_wdata_i;
  logic                 cfg_rvalid_o;
  logic [AddrWidth-1:0] cfg_rdata_o;
  logic                 cfg_err_o;

  logic                 lk_valid_i;
  logic                 lk_ready_o;
  logic [AddrWidth-1:0] lk_addr_i;

  logic                 res_valid_o;
  logic                 res_ready_i;
  logic                 res_hit_o;
  logic [2:0]           res_attr_o;

  logic                 locked_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
    input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    output lk_valid_i, lk_addr_i,
    input  lk_ready_o,
    input  res_valid_o, res_hit_o, res_attr_o,
    output res_ready_i,
    input  locked_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
    output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    input  lk_valid_i, lk_addr_i,
    output lk_ready_o,
    output res_valid_o, res_hit_o, res_attr_o,
    input  res_ready_i,
    output locked_o
  );
endinterface

// File: rtl/region_attr_table_match.sv
// Single-rule address compare. The end address is formed one bit wider than
// the address so a region touching the top of the space cannot wrap to zero.
module region_match #(
  parameter int AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] length_i,
  output logic                 match_o
);

  logic [AddrWidth:0] end_excl;

  assign end_excl = {1'b0, base_i} + {1'b0, length_i};
  assign match_o  = (length_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < end_excl);

endmodule

// File: rtl/region_attr_table.sv
// Programmable address-region attribute table: NrRules base/length rules,
// lowest index wins, one-cycle registered lookup with ready/valid, plus a
// register-style config port with a sticky write lock.
module region_attr_table
  import region_attr_table_pkg::*;
#(
  parameter int                    NrRules   = 4,
  parameter int                    AddrWidth = 64,
  parameter rule_t [NrRules-1:0]   RstRules  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  region_attr_table_if.slave   bus
);

  rule_t [NrRules-1:0]  rules_q;
  logic                 lock_q;
  logic                 cfg_rvalid_q;
  logic                 cfg_err_q;
  logic [AddrWidth-1:0] cfg_rdata_q;
  logic                 res_valid_q;
  logic                 res_hit_q;
  attr_t                res_attr_q;

  logic                 idx_ok;
  logic                 wr_en;
  logic [AddrWidth-1:0] rd_data_d;
  logic [NrRules-1:0]   match;
  logic                 hit_d;
  attr_t                attr_d;
  logic                 lk_accept;

  assign idx_ok    = int'(bus.cfg_idx_i) < NrRules;
  assign wr_en     = bus.cfg_req_i && bus.cfg_we_i && idx_ok && !lock_q;
  assign lk_accept = bus.lk_valid_i && bus.lk_ready_o;

  // Read mux: selected field zero-extended; out-of-range index reads zero.
  always_comb begin
    rd_data_d = '0;
    if (idx_ok) begin
      case (cfg_field_e'(bus.cfg_field_i))
        FieldBase:   rd_data_d = rules_q[bus.cfg_idx_i].base[AddrWidth-1:0];
        FieldLength: rd_data_d = rules_q[bus.cfg_idx_i].length[AddrWidth-1:0];
        FieldAttr:   rd_data_d = AddrWidth'(rules_q[bus.cfg_idx_i].attr);
        FieldLock:   rd_data_d = AddrWidth'(lock_q);
        default:     rd_data_d = '0;
      endcase
    end
  end

  // Config port: field updates, sticky lock and the one-cycle response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rules_q      <= RstRules;
      lock_q       <= 1'b0;
      cfg_rvalid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      cfg_rvalid_q <= bus.cfg_req_i;
      cfg_err_q    <= bus.cfg_req_i && (!idx_ok || (bus.cfg_we_i && lock_q));
      if (bus.cfg_req_i) begin
        cfg_rdata_q <= bus.cfg_we_i ? '0 : rd_data_d;
      end
      if (wr_en) begin
        case (cfg_field_e'(bus.cfg_field_i))
          FieldBase:   rules_q[bus.cfg_idx_i].base   <= addr_max_t'(bus.cfg_wdata_i);
          FieldLength: rules_q[bus.cfg_idx_i].length <= addr_max_t'(bus.cfg_wdata_i);
          FieldAttr:   rules_q[bus.cfg_idx_i].attr   <= bus.cfg_wdata_i[2:0];
          FieldLock:   if (bus.cfg_wdata_i[0]) lock_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    region_match #(.AddrWidth(AddrWidth)) u_match (
      .addr_i   (bus.lk_addr_i),
      .base_i   (rules_q[g].base[AddrWidth-1:0]),
      .length_i (rules_q[g].length[AddrWidth-1:0]),
      .match_o  (match[g])
    );
  end

  // Priority select: scan from the top so the lowest matching index wins.
  always_comb begin
    attr_d = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match[i]) attr_d = rules_q[i].attr;
    end
  end

  assign hit_d = |match;

  // Result register: load on accept, drop on consume, hold under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_attr_q  <= '0;
    end else if (lk_accept) begin
      res_valid_q <= 1'b1;
      res_hit_q   <= hit_d;
      res_attr_q  <= attr_d;
    end else if (bus.res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.lk_ready_o   = !res_valid_q || bus.res_ready_i;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.res_hit_o    = res_hit_q;
  assign bus.res_attr_o   = res_attr_q;
  assign bus.cfg_rvalid_o = cfg_rvalid_q;
  assign bus.cfg_err_o    = cfg_err_q;
  assign bus.cfg_rdata_o  = cfg_rdata_q;
  assign bus.locked_o     = lock_q;

endmodule

// File: tb/tb_region_attr_table.sv
// Directed bench for region_attr_table (3 rules, 64-bit addresses).
module tb_region_attr_table;
  import region_attr_table_pkg::*;

  localparam int NR = 3;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  region_attr_table_if #(.NrRules(NR), .AddrWidth(AW)) bus ();

  region_attr_table #(.NrRules(NR), .AddrWidth(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // One config access; response fields captured one cycle later.
  task automatic cfg_access(input logic we, input logic [1:0] idx, input logic [1:0] field,
                            input logic [AW-1:0] wdata,
                            output logic rv, output logic err, output logic [AW-1:0] rdata);
    bus.cfg_req_i   = 1'b1;
    bus.cfg_we_i    = we;
    bus.cfg_idx_i   = idx;
    bus.cfg_field_i = field;
    bus.cfg_wdata_i = wdata;
    @(posedge clk); #1;
    bus.cfg_req_i = 1'b0;
    bus.cfg_we_i  = 1'b0;
    rv    = bus.cfg_rvalid_o;
    err   = bus.cfg_err_o;
    rdata = bus.cfg_rdata_o;
  endtask

  // One lookup with res_ready high; result captured one cycle later.
  task automatic lookup(input logic [AW-1:0] addr, output logic vld, output logic hit,
                        output logic [2:0] attr);
    bus.res_ready_i = 1'b1;
    bus.lk_valid_i  = 1'b1;
    bus.lk_addr_i   = addr;
    @(posedge clk); #1;
    bus.lk_valid_i = 1'b0;
    vld  = bus.res_valid_o;
    hit  = bus.res_hit_o;
    attr = bus.res_attr_o;
  endtask

  task automatic test_reset();
    logic rv, err; logic [AW-1:0] rd;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.res_valid_o, bus.cfg_rvalid_o, bus.cfg_err_o, bus.locked_o, bus.res_hit_o, bus.res_attr_o} !== 8'h00)
      $display("FAIL reset_outputs: got vld=%b rv=%b err=%b lock=%b hit=%b attr=%b, want all 0",
               bus.res_valid_o, bus.cfg_rvalid_o, bus.cfg_err_o, bus.locked_o, bus.res_hit_o, bus.res_attr_o);
    else passes++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.lk_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.lk_ready_o);
    else passes++;
    cfg_access(1'b0, 2'd1, 2'd0, '0, rv, err, rd);
    checks++;
    if (rv !== 1'b1 || err !== 1'b0 || rd !== '0)
      $display("FAIL reset_rule_base: got rv=%b err=%b rd=%h want 1 0 0", rv, err, rd);
    else passes++;
  endtask

  task automatic test_single_rule();
    logic rv, err, vld, hit; logic [AW-1:0] rd; logic [2:0] attr;
    logic [AW-1:0] addrs [4] = '{64'hBFFF_FFFF, 64'hC000_0000, 64'h8000_0000, 64'h7FFF_FFFF};
    logic          ehit  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]    eattr [4] = '{3'b011, 3'b000, 3'b011, 3'b000};
    cfg_access(1'b1, 2'd0, 2'd0, 64'h8000_0000, rv, err, rd);
    checks++;
    if (rv !== 1'b1 || err !== 1'b0) $display("FAIL wr_resp: got rv=%b err=%b want 1 0", rv, err);
    else passes++;
    checks++;
    if (bus.cfg_rvalid_o !== 1'b1) $display("FAIL rv_pulse_missing: got %b want 1", bus.cfg_rvalid_o);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (bus.cfg_rvalid_o !== 1'b0) $display("FAIL rv_one_cycle: got %b want 0", bus.cfg_rvalid_o);
    else passes++;
    cfg_access(1'b1, 2'd0, 2'd1, 64'h4000_0000, rv, err, rd);
    cfg_access(1'b1, 2'd0, 2'd2, 64'h3, rv, err, rd);
    cfg_access(1'b0, 2'd0, 2'd0, '0, rv, err, rd);
    checks++;
    if (rd !== 64'h8000_0000 || err !== 1'b0) $display("FAIL rd_base: got %h err=%b want 80000000 0", rd, err);
    else passes++;
    cfg_access(1'b0, 2'd0, 2'd2, '0, rv, err, rd);
    checks++;
    if (rd !== 64'h3) $display("FAIL rd_attr: got %h want 3", rd);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      lookup(addrs[i], vld, hit, attr);
      checks++;
      if (vld !== 1'b1 || hit !== ehit[i] || attr !== eattr[i])
        $display("FAIL single_rule[%0d]: got vld=%b hit=%b attr=%b want 1 %b %b", i, vld, hit, attr, ehit[i], eattr[i]);
      else passes++;
    end
  endtask

  task automatic test_priority();
    logic rv, err, vld, hit; logic [AW-1:0] rd; logic [2:0] attr;
    cfg_access(1'b1, 2'd0, 2'd0, 64'h1_0000, rv, err, rd);
    cfg_access(1'b1, 2'd0, 2'd1, 64'h1_0000, rv, err, rd);
    cfg_access(1'b1, 2'd0, 2'd2, 64'h2, rv, err, rd);
    cfg_access(1'b1, 2'd1, 2'd0, 64'h0, rv, err, rd);
    cfg_access(1'b1, 2'd1, 2'd1, 64'h10_0000, rv, err, rd);
    cfg_access(1'b1, 2'd1, 2'd2, 64'h4, rv, err, rd);
    lookup(64'h1_8000, vld, hit, attr);
    checks++;
    if (hit !== 1'b1 || attr !== 3'b010) $display("FAIL prio_rule0: got hit=%b attr=%b want 1 010", hit, attr);
    else passes++;
    lookup(64'h2_0000, vld, hit, attr);
    checks++;
    if (hit !== 1'b1 || attr !== 3'b100) $display("FAIL prio_rule1: got hit=%b attr=%b want 1 100", hit, attr);
    else passes++;
  endtask

  task automatic test_no_wrap();
    logic rv, err, vld, hit; logic [AW-1:0] rd; logic [2:0] attr;
    cfg_access(1'b1, 2'd2, 2'd0, 64'hFFFF_FFFF_FFFF_F000, rv, err, rd);
    cfg_access(1'b1, 2'd2, 2'd1, 64'h2000, rv, err, rd);
    cfg_access(1'b1, 2'd2, 2'd2, 64'h1, rv, err, rd);
    cfg_access(1'b1, 2'd1, 2'd1, 64'h0, rv, err, rd);
    lookup(64'h10, vld, hit, attr);
    checks++;
    if (hit !== 1'b0 || attr !== 3'b000) $display("FAIL no_wrap: got hit=%b attr=%b want 0 000", hit, attr);
    else passes++;
    lookup(64'hFFFF_FFFF_FFFF_FFFF, vld, hit, attr);
    checks++;
    if (hit !== 1'b1 || attr !== 3'b001) $display("FAIL top_of_space: got hit=%b attr=%b want 1 001", hit, attr);
    else passes++;
    lookup(64'h5000, vld, hit, attr);
    checks++;
    if (hit !== 1'b0 || attr !== 3'b000) $display("FAIL len_zero: got hit=%b attr=%b want 0 000", hit, attr);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] addrs [5] = '{64'h1_0000, 64'h10, 64'hFFFF_FFFF_FFFF_F800, 64'h1_FFFF, 64'h2_0000};
    logic          ehit  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]    eattr [5] = '{3'b010, 3'b000, 3'b001, 3'b010, 3'b000};
    int  sent = 0, rcvd = 0, cyc = 0;
    logic pending = 1'b0, exp_rdy, acc;
    @(posedge clk); #1;
    while (rcvd < 5 && cyc < 30) begin
      bus.lk_valid_i  = (sent < 5);
      bus.lk_addr_i   = (sent < 5) ? addrs[sent] : '0;
      bus.res_ready_i = !(cyc >= 2 && cyc <= 4);
      #4;
      exp_rdy = !pending || bus.res_ready_i;
      checks++;
      if (bus.lk_ready_o !== exp_rdy || bus.res_valid_o !== pending)
        $display("FAIL bp_handshake[c%0d]: got rdy=%b vld=%b want %b %b", cyc, bus.lk_ready_o, bus.res_valid_o, exp_rdy, pending);
      else passes++;
      if (pending) begin
        checks++;
        if (bus.res_hit_o !== ehit[rcvd] || bus.res_attr_o !== eattr[rcvd])
          $display("FAIL bp_result[%0d]: got hit=%b attr=%b want %b %b", rcvd, bus.res_hit_o, bus.res_attr_o, ehit[rcvd], eattr[rcvd]);
        else passes++;
        if (bus.res_ready_i) rcvd++;
      end
      acc = bus.lk_valid_i && exp_rdy;
      if (acc) sent++;
      pending = acc ? 1'b1 : (bus.res_ready_i ? 1'b0 : pending);
      @(posedge clk); #1;
      cyc++;
    end
    bus.lk_valid_i  = 1'b0;
    bus.res_ready_i = 1'b1;
    checks++;
    if (rcvd != 5 || sent != 5) $display("FAIL bp_count: got sent=%0d rcvd=%0d want 5 5", sent, rcvd);
    else passes++;
    checks++;
    if (bus.res_valid_o !== 1'b0) $display("FAIL bp_duplicate: got res_valid=%b want 0", bus.res_valid_o);
    else passes++;
  endtask

  task automatic test_same_cycle();
    logic vld, hit; logic [2:0] attr;
    bus.res_ready_i = 1'b1;
    bus.cfg_req_i   = 1'b1;
    bus.cfg_we_i    = 1'b1;
    bus.cfg_idx_i   = 2'd0;
    bus.cfg_field_i = 2'd2;
    bus.cfg_wdata_i = 64'h7;
    bus.lk_valid_i  = 1'b1;
    bus.lk_addr_i   = 64'h1_0000;
    @(posedge clk); #1;
    bus.cfg_req_i  = 1'b0;
    bus.cfg_we_i   = 1'b0;
    bus.lk_valid_i = 1'b0;
    checks++;
    if (bus.cfg_rvalid_o !== 1'b1 || bus.cfg_err_o !== 1'b0 || bus.res_valid_o !== 1'b1 ||
        bus.res_hit_o !== 1'b1 || bus.res_attr_o !== 3'b010)
      $display("FAIL same_cycle_old: got rv=%b err=%b vld=%b hit=%b attr=%b want 1 0 1 1 010",
               bus.cfg_rvalid_o, bus.cfg_err_o, bus.res_valid_o, bus.res_hit_o, bus.res_attr_o);
    else passes++;
    lookup(64'h1_0000, vld, hit, attr);
    checks++;
    if (hit !== 1'b1 || attr !== 3'b111) $display("FAIL same_cycle_new: got hit=%b attr=%b want 1 111", hit, attr);
    else passes++;
  endtask

  task automatic test_bad_index();
    logic rv, err; logic [AW-1:0] rd;
    cfg_access(1'b1, 2'd3, 2'd0, 64'hDEAD, rv, err, rd);
    checks++;
    if (rv !== 1'b1 || err !== 1'b1) $display("FAIL bad_idx_wr: got rv=%b err=%b want 1 1", rv, err);
    else passes++;
    cfg_access(1'b0, 2'd3, 2'd0, '0, rv, err, rd);
    checks++;
    if (err !== 1'b1 || rd !== '0) $display("FAIL bad_idx_rd: got err=%b rd=%h want 1 0", err, rd);
    else passes++;
    cfg_access(1'b1, 2'd3, 2'd3, 64'h1, rv, err, rd);
    checks++;
    if (err !== 1'b1 || bus.locked_o !== 1'b0) $display("FAIL bad_idx_lock: got err=%b lock=%b want 1 0", err, bus.locked_o);
    else passes++;
  endtask

  task automatic test_lock();
    logic rv, err, vld, hit; logic [AW-1:0] rd; logic [2:0] attr;
    cfg_access(1'b1, 2'd2, 2'd3, 64'h1, rv, err, rd);
    checks++;
    if (err !== 1'b0 || bus.locked_o !== 1'b1) $display("FAIL lock_set: got err=%b lock=%b want 0 1", err, bus.locked_o);
    else passes++;
    cfg_access(1'b1, 2'd0, 2'd0, 64'h1234, rv, err, rd);
    checks++;
    if (rv !== 1'b1 || err !== 1'b1) $display("FAIL locked_wr: got rv=%b err=%b want 1 1", rv, err);
    else passes++;
    cfg_access(1'b0, 2'd0, 2'd0, '0, rv, err, rd);
    checks++;
    if (err !== 1'b0 || rd !== 64'h1_0000) $display("FAIL locked_readback: got err=%b rd=%h want 0 10000", err, rd);
    else passes++;
    cfg_access(1'b0, 2'd1, 2'd3, '0, rv, err, rd);
    checks++;
    if (rd !== 64'h1) $display("FAIL lock_rd: got %h want 1", rd);
    else passes++;
    lookup(64'h1_0000, vld, hit, attr);
    checks++;
    if (hit !== 1'b1 || attr !== 3'b111) $display("FAIL locked_lookup: got hit=%b attr=%b want 1 111", hit, attr);
    else passes++;
  endtask

  task automatic test_reset_pending();
    logic rv, err; logic [AW-1:0] rd;
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
    bus.lk_valid_i  = 1'b1;
    bus.lk_addr_i   = 64'h1_0000;
    @(posedge clk); #1;
    bus.lk_valid_i = 1'b0;
    checks++;
    if (bus.res_valid_o !== 1'b1) $display("FAIL pend_setup: got vld=%b want 1", bus.res_valid_o);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.res_valid_o !== 1'b0 || bus.locked_o !== 1'b0 || bus.res_hit_o !== 1'b0)
      $display("FAIL pend_async_rst: got vld=%b lock=%b hit=%b want 0 0 0", bus.res_valid_o, bus.locked_o, bus.res_hit_o);
    else passes++;
    @(negedge clk); rst = 1'b0;
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.res_valid_o !== 1'b0 || bus.lk_ready_o !== 1'b1)
      $display("FAIL pend_after_rst: got vld=%b rdy=%b want 0 1", bus.res_valid_o, bus.lk_ready_o);
    else passes++;
    cfg_access(1'b0, 2'd0, 2'd0, '0, rv, err, rd);
    checks++;
    if (rd !== '0) $display("FAIL rst_rules_reload: got %h want 0", rd);
    else passes++;
  endtask

  initial begin
    bus.cfg_req_i   = 1'b0;
    bus.cfg_we_i    = 1'b0;
    bus.cfg_idx_i   = '0;
    bus.cfg_field_i = '0;
    bus.cfg_wdata_i = '0;
    bus.lk_valid_i  = 1'b0;
    bus.lk_addr_i   = '0;
    bus.res_ready_i = 1'b1;
    #1;
    test_reset();
    test_single_rule();
    test_priority();
    test_no_wrap();
    test_backpressure();
    test_same_cycle();
    test_bad_index();
    test_lock();
    test_reset_pending();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/region_attr_table.md
REGION_ATTR_TABLE -- requirements
Module: region_attr_table

Interface
REQ-001 The block SHALL have parameter NrRules, default 4, which sets the number of programmable address rules (1..16).
REQ-002 The block SHALL have parameter AddrWidth, default 64, which sets the address, base and length width.
REQ-003 The block SHALL have parameter RstRules, default all-zero, which holds the reset image of the rules (base, length, attr per rule).
REQ-004 clk_i  in  1  the single clock for the block.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 cfg_req_i  in  1  configuration access request.
REQ-007 cfg_we_i  in  1  1 = write, 0 = read.
REQ-008 cfg_idx_i  in  $clog2(NrRules)  rule index.
REQ-009 cfg_field_i  in  2  field select: 0 = base, 1 = length, 2 = attr, 3 = lock.
REQ-010 cfg_wdata_i  in  AddrWidth  write data.
REQ-011 cfg_rvalid_o  out  1  response valid, exactly one cycle after the request.
REQ-012 cfg_rdata_o  out  AddrWidth  read data.
REQ-013 cfg_err_o  out  1  response error flag.
REQ-014 lk_valid_i / lk_ready_o  in/out  1  lookup request handshake.
REQ-015 lk_addr_i  in  AddrWidth  lookup address.
REQ-016 res_valid_o / res_ready_i  out/in  1  result handshake.
REQ-017 res_hit_o  out  1  at least one rule matched.
REQ-018 res_attr_o  out  3  {nonidempotent, exec, cached} of the winning rule.
REQ-019 locked_o  out  1  table lock status.

Function
REQ-020 Rule i SHALL match when length_i != 0 and base_i <= addr < base_i + length_i, with the sum computed in AddrWidth+1 bits so that it cannot wrap.
REQ-021 When several rules match, the lowest index SHALL win; when none match, res_hit_o SHALL be 0 and res_attr_o SHALL be 3'b000.
REQ-022 Lookup latency SHALL be one cycle: a request accepted in cycle N (lk_valid_i && lk_ready_o) SHALL present its result in cycle N+1.
REQ-023 The result stage SHALL be a single output register; lk_ready_o = !res_valid_o || res_ready_i, so back-to-back lookups sustain one per cycle.
REQ-024 While res_valid_o && !res_ready_i, res_hit_o and res_attr_o SHALL stay stable.
REQ-025 A lookup SHALL use the table contents as they are at the start of its acceptance cycle; a config write in the same cycle SHALL take effect for lookups accepted from the next cycle onward.
REQ-026 A config write SHALL update the selected field at the clock edge; cfg_rvalid_o SHALL pulse in the next cycle with cfg_err_o = 0.
REQ-027 A config read SHALL return the field zero-extended to AddrWidth (attr in bits [2:0], lock in bit 0) one cycle later.
REQ-028 cfg_idx_i >= NrRules SHALL produce cfg_err_o = 1 and no state change; a read then returns 0.
REQ-029 A write of 1 to the lock field (any index) SHALL set the lock; the lock is sticky until reset.
REQ-030 While locked_o = 1, writes SHALL be discarded and SHALL respond with cfg_err_o = 1; reads SHALL be unaffected.
REQ-031 Config access SHALL never stall the lookup path, and lookup SHALL never stall config access.

Reset
REQ-032 On reset, the rules SHALL load RstRules, and res_valid_o, cfg_rvalid_o, cfg_err_o and locked_o SHALL be 0.
REQ-033 On reset, res_hit_o and res_attr_o SHALL be 0, and lk_ready_o SHALL be 1 from the first cycle after reset is released.
REQ-034 A reset asserted while a result is pending SHALL discard that result without delivering it.

Structure
REQ-035 The rule_t struct (base, length, attr), the attr bit positions and the cfg_field encoding SHALL live in a shared package.
REQ-036 A single sub-module, region_match (one rule compare, purely combinational), SHALL be instantiated NrRules times.

Verification
REQ-037 Rule0 = {0x8000_0000, 0x4000_0000, cached|exec}; lookup 0xBFFF_FFFF -> hit = 1, attr = 3'b011; lookup 0xC000_0000 -> hit = 0, attr = 0.
REQ-038 Rule0 = {0x1_0000, 0x10000, exec}, rule1 = {0x0, 0x10_0000, nonidem}; lookup 0x1_8000 -> attr = 3'b010 (rule0 wins over rule1).
REQ-039 Base = 0xFFFF_FFFF_FFFF_F000 with length 0x2000, lookup 0x10 -> no match (no wrap-around); length 0 -> rule never matches.
REQ-040 Hold res_ready_i = 0 for 3 cycles during a stream of lookups -> result held stable, lk_ready_o = 0, no lookup lost or duplicated.
REQ-041 Write lock = 1, then write base -> cfg_err_o = 1 and read-back shows the old base; write idx = NrRules -> cfg_err_o = 1.
REQ-042 Write rule0 attr in the same cycle a lookup is accepted -> that result uses the old attr and the next lookup uses the new attr.
